// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU op sequencer: opcodes, step encoding,
// one-hot ALU function positions, IR field offsets and the output bundle.
package alu_op_sequencer_pkg;

    localparam int IR_W      = 32;
    localparam int NUM_REGS  = 16;
    localparam int REG_SEL_W = 4;
    localparam int OPC_W     = 5;
    localparam int NUM_OPS   = 13;

    // IR field positions: opc=ir[31:27], ra=ir[26:23], rb=ir[22:19], rc=ir[18:15]
    localparam int OPC_LSB = IR_W - OPC_W;
    localparam int RA_LSB  = OPC_LSB - REG_SEL_W;
    localparam int RB_LSB  = RA_LSB - REG_SEL_W;
    localparam int RC_LSB  = RB_LSB - REG_SEL_W;

    // Index of each register field in the per-field decoder array
    localparam int FLD_RA = 0;
    localparam int FLD_RB = 1;
    localparam int FLD_RC = 2;

    localparam logic [OPC_W-1:0] OPC_ADD  = 5'd0;
    localparam logic [OPC_W-1:0] OPC_SUB  = 5'd1;
    localparam logic [OPC_W-1:0] OPC_AND  = 5'd2;
    localparam logic [OPC_W-1:0] OPC_OR   = 5'd3;
    localparam logic [OPC_W-1:0] OPC_ROR  = 5'd4;
    localparam logic [OPC_W-1:0] OPC_ROL  = 5'd5;
    localparam logic [OPC_W-1:0] OPC_SHR  = 5'd6;
    localparam logic [OPC_W-1:0] OPC_SHRA = 5'd7;
    localparam logic [OPC_W-1:0] OPC_SHL  = 5'd8;
    localparam logic [OPC_W-1:0] OPC_MUL  = 5'd16;
    localparam logic [OPC_W-1:0] OPC_DIV  = 5'd17;
    localparam logic [OPC_W-1:0] OPC_NEG  = 5'd18;
    localparam logic [OPC_W-1:0] OPC_NOT  = 5'd19;

    // Bit positions inside the one-hot alu_op vector
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_ROR  = 4;
    localparam int ALU_ROL  = 5;
    localparam int ALU_SHR  = 6;
    localparam int ALU_SHRA = 7;
    localparam int ALU_SHL  = 8;
    localparam int ALU_MUL  = 9;
    localparam int ALU_DIV  = 10;
    localparam int ALU_NEG  = 11;
    localparam int ALU_NOT  = 12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5
    } state_t;

    typedef enum logic [1:0] {
        CLS_BIN,
        CLS_MULDIV,
        CLS_UNARY,
        CLS_BAD
    } op_class_t;

    // Every registered control output except busy, which follows the state
    typedef struct packed {
        logic                done;
        logic                illegal;
        logic [NUM_REGS-1:0] reg_out;
        logic [NUM_REGS-1:0] reg_in;
        logic                pc_out;
        logic                mdr_out;
        logic                zhigh_out;
        logic                zlow_out;
        logic                pc_in;
        logic                ir_in;
        logic                mar_in;
        logic                mdr_in;
        logic                y_in;
        logic                z_in;
        logic                hi_in;
        logic                lo_in;
        logic                read;
        logic                inc_pc;
        logic [NUM_OPS-1:0]  alu_op;
    } ctrl_out_t;

    function automatic op_class_t op_class(input logic [OPC_W-1:0] opc);
        op_class_t cls;
        case (opc)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_ROR,
            OPC_ROL, OPC_SHR, OPC_SHRA, OPC_SHL: cls = CLS_BIN;
            OPC_MUL, OPC_DIV:                    cls = CLS_MULDIV;
            OPC_NEG, OPC_NOT:                    cls = CLS_UNARY;
            default:                             cls = CLS_BAD;
        endcase
        return cls;
    endfunction

    function automatic logic [NUM_OPS-1:0] alu_onehot(input logic [OPC_W-1:0] opc);
        logic [NUM_OPS-1:0] op;
        op = '0;
        case (opc)
            OPC_ADD:  op[ALU_ADD]  = 1'b1;
            OPC_SUB:  op[ALU_SUB]  = 1'b1;
            OPC_AND:  op[ALU_AND]  = 1'b1;
            OPC_OR:   op[ALU_OR]   = 1'b1;
            OPC_ROR:  op[ALU_ROR]  = 1'b1;
            OPC_ROL:  op[ALU_ROL]  = 1'b1;
            OPC_SHR:  op[ALU_SHR]  = 1'b1;
            OPC_SHRA: op[ALU_SHRA] = 1'b1;
            OPC_SHL:  op[ALU_SHL]  = 1'b1;
            OPC_MUL:  op[ALU_MUL]  = 1'b1;
            OPC_DIV:  op[ALU_DIV]  = 1'b1;
            OPC_NEG:  op[ALU_NEG]  = 1'b1;
            OPC_NOT:  op[ALU_NOT]  = 1'b1;
            default:  op = '0;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_sel_decoder.sv
// Register index to one-hot enable decoder with an out-of-range flag for
// index values that name no implemented register.
module reg_sel_decoder #(
    parameter int NUM_REGS = 16,
    parameter int SEL_W    = 4
) (
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot,
    output logic                out_of_range
);

    genvar gi;
    // One comparator per register enable
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_bit
        assign onehot[gi] = (sel == SEL_W'(gi));
    end

    // Flags indices past the last implemented register
    assign out_of_range = (32'(sel) >= NUM_REGS);

endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle control sequencer: fetch (T0/T1) then per-class execute steps.
// All control outputs are registered and decoded from the next state, so a
// step's enables appear in the same cycle the state register enters it.
// The IR fields are decoded while leaving T1, so ir must already carry the
// fetched instruction at that edge and stay stable until done.
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mem_rdy,
    input  logic [IR_W-1:0]     ir,
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [NUM_REGS-1:0] reg_out,
    output logic [NUM_REGS-1:0] reg_in,
    output logic                pc_out,
    output logic                mdr_out,
    output logic                zhigh_out,
    output logic                zlow_out,
    output logic                pc_in,
    output logic                ir_in,
    output logic                mar_in,
    output logic                mdr_in,
    output logic                y_in,
    output logic                z_in,
    output logic                hi_in,
    output logic                lo_in,
    output logic                read,
    output logic                inc_pc,
    output logic [NUM_OPS-1:0]  alu_op
);

    state_t    state_q, state_d;
    ctrl_out_t ctl_q, ctl_d;
    logic      busy_q, busy_d;

    logic [OPC_W-1:0]     opc;
    logic [REG_SEL_W-1:0] fld_sel [3];
    logic [NUM_REGS-1:0]  fld_oh  [3];
    logic [2:0]           fld_oor;
    op_class_t            cls;
    logic                 bad_instr;
    logic [NUM_OPS-1:0]   alu_sel;
    logic                 unused_ir_bits;

    assign opc              = ir[OPC_LSB +: OPC_W];
    assign fld_sel[FLD_RA]  = ir[RA_LSB +: REG_SEL_W];
    assign fld_sel[FLD_RB]  = ir[RB_LSB +: REG_SEL_W];
    assign fld_sel[FLD_RC]  = ir[RC_LSB +: REG_SEL_W];
    assign unused_ir_bits   = ^ir[RC_LSB-1:0];

    genvar gi;
    // One decoder per register field; the step logic picks which one drives the bus
    for (gi = 0; gi < 3; gi++) begin : g_fld
        reg_sel_decoder #(
            .NUM_REGS (NUM_REGS),
            .SEL_W    (REG_SEL_W)
        ) u_dec (
            .sel          (fld_sel[gi]),
            .onehot       (fld_oh[gi]),
            .out_of_range (fld_oor[gi])
        );
    end

    assign cls     = op_class(opc);
    assign alu_sel = alu_onehot(opc);
    // Unknown opcode, or a field actually used by this op names no register
    assign bad_instr = (cls == CLS_BAD) || fld_oor[FLD_RA] || fld_oor[FLD_RB]
                     || ((cls == CLS_BIN) && fld_oor[FLD_RC]);

    // Next-state and next-output decode; every step starts from all-zero controls
    always_comb begin
        state_d = state_q;
        ctl_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_T0;
                    ctl_d.pc_out = 1'b1;
                    ctl_d.mar_in = 1'b1;
                    ctl_d.inc_pc = 1'b1;
                    ctl_d.pc_in  = 1'b1;
                    ctl_d.read   = 1'b1;
                    ctl_d.mdr_in = 1'b1;
                end
            end
            S_T0: begin
                if (mem_rdy) begin
                    state_d       = S_T1;
                    ctl_d.mdr_out = 1'b1;
                    ctl_d.ir_in   = 1'b1;
                end else begin
                    // Wait for memory: keep the read and MDR capture, PC already advanced
                    ctl_d.read   = 1'b1;
                    ctl_d.mdr_in = 1'b1;
                end
            end
            S_T1: begin
                state_d = S_T2;
                if (bad_instr) begin
                    ctl_d.illegal = 1'b1;
                end else begin
                    case (cls)
                        CLS_BIN: begin
                            ctl_d.reg_out = fld_oh[FLD_RB];
                            ctl_d.y_in    = 1'b1;
                        end
                        CLS_MULDIV: begin
                            ctl_d.reg_out = fld_oh[FLD_RA];
                            ctl_d.y_in    = 1'b1;
                        end
                        CLS_UNARY: begin
                            ctl_d.reg_out = fld_oh[FLD_RB];
                            ctl_d.alu_op  = alu_sel;
                            ctl_d.z_in    = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_T2: begin
                if (ctl_q.illegal) begin
                    state_d = S_IDLE;
                end else begin
                    case (cls)
                        CLS_BIN: begin
                            state_d       = S_T3;
                            ctl_d.reg_out = fld_oh[FLD_RC];
                            ctl_d.alu_op  = alu_sel;
                            ctl_d.z_in    = 1'b1;
                        end
                        CLS_MULDIV: begin
                            state_d       = S_T3;
                            ctl_d.reg_out = fld_oh[FLD_RB];
                            ctl_d.alu_op  = alu_sel;
                            ctl_d.z_in    = 1'b1;
                        end
                        CLS_UNARY: begin
                            state_d        = S_T3;
                            ctl_d.zlow_out = 1'b1;
                            ctl_d.reg_in   = fld_oh[FLD_RA];
                            ctl_d.done     = 1'b1;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_T3: begin
                case (cls)
                    CLS_BIN: begin
                        state_d        = S_T4;
                        ctl_d.zlow_out = 1'b1;
                        ctl_d.reg_in   = fld_oh[FLD_RA];
                        ctl_d.done     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        state_d        = S_T4;
                        ctl_d.zlow_out = 1'b1;
                        ctl_d.lo_in    = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            S_T4: begin
                if (cls == CLS_MULDIV) begin
                    state_d         = S_T5;
                    ctl_d.zhigh_out = 1'b1;
                    ctl_d.hi_in     = 1'b1;
                    ctl_d.done      = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_T5: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and control registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ctl_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            busy_q  <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = ctl_q.done;
    assign illegal   = ctl_q.illegal;
    assign reg_out   = ctl_q.reg_out;
    assign reg_in    = ctl_q.reg_in;
    assign pc_out    = ctl_q.pc_out;
    assign mdr_out   = ctl_q.mdr_out;
    assign zhigh_out = ctl_q.zhigh_out;
    assign zlow_out  = ctl_q.zlow_out;
    assign pc_in     = ctl_q.pc_in;
    assign ir_in     = ctl_q.ir_in;
    assign mar_in    = ctl_q.mar_in;
    assign mdr_in    = ctl_q.mdr_in;
    assign y_in      = ctl_q.y_in;
    assign z_in      = ctl_q.z_in;
    assign hi_in     = ctl_q.hi_in;
    assign lo_in     = ctl_q.lo_in;
    assign read      = ctl_q.read;
    assign inc_pc    = ctl_q.inc_pc;
    assign alu_op    = ctl_q.alu_op;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: directed cases plus random instructions, each
// checked cycle by cycle against a step-list model of the instruction classes.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mem_rdy;
    logic [31:0] ir;
    logic        busy, done, illegal;
    logic [15:0] reg_out, reg_in;
    logic        pc_out, mdr_out, zhigh_out, zlow_out;
    logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
    logic        read, inc_pc;
    logic [12:0] alu_op;

    typedef struct packed {
        logic        busy, done, illegal;
        logic [15:0] reg_out, reg_in;
        logic        pc_out, mdr_out, zhigh_out, zlow_out;
        logic        pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in;
        logic        read, inc_pc;
        logic [12:0] alu_op;
    } ctl_t;

    ctl_t exp_q[$];
    int   exp_latency;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    alu_op_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .mem_rdy(mem_rdy), .ir(ir),
        .busy(busy), .done(done), .illegal(illegal),
        .reg_out(reg_out), .reg_in(reg_in),
        .pc_out(pc_out), .mdr_out(mdr_out), .zhigh_out(zhigh_out), .zlow_out(zlow_out),
        .pc_in(pc_in), .ir_in(ir_in), .mar_in(mar_in), .mdr_in(mdr_in),
        .y_in(y_in), .z_in(z_in), .hi_in(hi_in), .lo_in(lo_in),
        .read(read), .inc_pc(inc_pc), .alu_op(alu_op)
    );

    // ALU function index of each supported opcode, -1 when unsupported
    function automatic int op_index(input logic [4:0] opc);
        if (opc <= 5'd8) return int'(opc);
        case (opc)
            5'd16:   return 9;
            5'd17:   return 10;
            5'd18:   return 11;
            5'd19:   return 12;
            default: return -1;
        endcase
    endfunction

    function automatic ctl_t busy_step();
        ctl_t c;
        c = '0;
        c.busy = 1'b1;
        return c;
    endfunction

    // Expected per-cycle outputs after the start edge, from the instruction's step list
    function automatic void build(input logic [31:0] irv, input int nwait);
        ctl_t c;
        int idx;
        logic [3:0] ra, rb, rc;
        ra = irv[26:23];
        rb = irv[22:19];
        rc = irv[18:15];
        idx = op_index(irv[31:27]);
        exp_q.delete();
        c = busy_step();
        c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.pc_in = 1; c.read = 1; c.mdr_in = 1;
        exp_q.push_back(c);
        for (int k = 0; k < nwait; k++) begin
            c = busy_step(); c.read = 1; c.mdr_in = 1;
            exp_q.push_back(c);
        end
        c = busy_step(); c.mdr_out = 1; c.ir_in = 1;
        exp_q.push_back(c);
        if (idx < 0) begin
            c = busy_step(); c.illegal = 1;
            exp_q.push_back(c);
            exp_latency = -1;
        end else if (idx <= 8) begin
            c = busy_step(); c.reg_out = 16'd1 << rb; c.y_in = 1;
            exp_q.push_back(c);
            c = busy_step(); c.reg_out = 16'd1 << rc; c.alu_op = 13'd1 << idx; c.z_in = 1;
            exp_q.push_back(c);
            c = busy_step(); c.zlow_out = 1; c.reg_in = 16'd1 << ra; c.done = 1;
            exp_q.push_back(c);
            exp_latency = 5 + nwait;
        end else if (idx <= 10) begin
            c = busy_step(); c.reg_out = 16'd1 << ra; c.y_in = 1;
            exp_q.push_back(c);
            c = busy_step(); c.reg_out = 16'd1 << rb; c.alu_op = 13'd1 << idx; c.z_in = 1;
            exp_q.push_back(c);
            c = busy_step(); c.zlow_out = 1; c.lo_in = 1;
            exp_q.push_back(c);
            c = busy_step(); c.zhigh_out = 1; c.hi_in = 1; c.done = 1;
            exp_q.push_back(c);
            exp_latency = 6 + nwait;
        end else begin
            c = busy_step(); c.reg_out = 16'd1 << rb; c.alu_op = 13'd1 << idx; c.z_in = 1;
            exp_q.push_back(c);
            c = busy_step(); c.zlow_out = 1; c.reg_in = 16'd1 << ra; c.done = 1;
            exp_q.push_back(c);
            exp_latency = 4 + nwait;
        end
    endfunction

    function automatic ctl_t sample();
        ctl_t o;
        o = '{busy, done, illegal, reg_out, reg_in, pc_out, mdr_out, zhigh_out, zlow_out,
              pc_in, ir_in, mar_in, mdr_in, y_in, z_in, hi_in, lo_in, read, inc_pc, alu_op};
        return o;
    endfunction

    task automatic check(input string tag, input int step, input ctl_t exp_v);
        ctl_t obs;
        int nsrc;
        obs = sample();
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s step %0d: observed %h expected %h", tag, step, obs, exp_v);
        end
        nsrc = int'(pc_out) + int'(mdr_out) + int'(zhigh_out) + int'(zlow_out) + int'(reg_out != '0);
        vectors++;
        assert (nsrc <= 1 && $onehot0(reg_out) && $onehot0(alu_op)) else begin
            miscompares++;
            $error("FAIL %s_bus step %0d: observed sources=%0d reg_out=%h alu_op=%h expected at most one", tag, step, nsrc, reg_out, alu_op);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // start_mode: 0 start low while busy, 1 random while busy, 2 held high
    task automatic run_instr(input string tag, input logic [31:0] irv, input int nwait, input int start_mode);
        int rd_cnt, inc_cnt, done_at, n;
        build(irv, nwait);
        n = exp_q.size();
        ir = irv;
        start = 1'b1;
        mem_rdy = 1'($urandom_range(0, 1));
        rd_cnt = 0; inc_cnt = 0; done_at = -1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check(tag, i, exp_q[i]);
            if (read) rd_cnt++;
            if (inc_pc) inc_cnt++;
            if (done && done_at < 0) done_at = i + 1;
            case (start_mode)
                0:       start = 1'b0;
                1:       start = 1'($urandom_range(0, 1));
                default: start = 1'b1;
            endcase
            if (i < nwait)       mem_rdy = 1'b0;
            else if (i == nwait) mem_rdy = 1'b1;
            else                 mem_rdy = 1'($urandom_range(0, 1));
        end
        @(posedge clk); #1;
        check({tag, "_idle"}, n, '0);
        check_int({tag, "_latency"}, done_at, exp_latency);
        check_int({tag, "_read_cycles"}, rd_cnt, nwait + 1);
        check_int({tag, "_inc_pc_cycles"}, inc_cnt, 1);
        $display("instr %s ir=%h wait=%0d start_mode=%0d done_at=%0d", tag, irv, nwait, start_mode, done_at);
    endtask

    logic [4:0] legal_ops [13] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
                                   5'd16, 5'd17, 5'd18, 5'd19};

    initial begin
        logic [4:0] opc;
        logic [31:0] irv;
        reset = 1'b0; start = 1'b0; mem_rdy = 1'b0; ir = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset", 0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 0, '0);

        // Directed: MUL R2,R6 / ADD R2,R4,R3 / memory wait / illegal opcode
        run_instr("mul_r2_r6", 32'h81300000, 0, 0);
        run_instr("add_r2_r4_r3", 32'h01218000, 0, 0);
        run_instr("mem_wait3", 32'h01218000, 3, 0);
        run_instr("illegal_31", {5'd31, 27'h1234567}, 0, 0);
        run_instr("neg_same_regs", {5'd18, 4'd7, 4'd7, 4'd0, 15'h0}, 1, 0);
        run_instr("sub_ra_eq_rb", {5'd1, 4'd15, 4'd15, 4'd15, 15'h7fff}, 0, 0);
        start = 1'b0;

        // Async reset in T3 of a MUL
        ir = 32'h81300000;
        build(ir, 0);
        mem_rdy = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mul_pre_reset", i, exp_q[i]);
            start = 1'b0;
        end
        #3 reset = 1'b0;
        #1;
        check("async_reset", 0, '0);
        @(posedge clk); #1;
        check("reset_held", 0, '0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_release_idle", 0, '0);
        run_instr("mul_after_reset", 32'h81300000, 0, 0);

        // Start held high: back-to-back instructions with one IDLE cycle between
        run_instr("b2b_div", {5'd17, 4'd3, 4'd9, 4'd1, 15'h0}, 0, 2);
        run_instr("b2b_not", {5'd19, 4'd1, 4'd12, 4'd5, 15'h0}, 2, 2);
        run_instr("b2b_shl", {5'd8, 4'd0, 4'd14, 4'd13, 15'h0}, 0, 2);

        // Random instructions, including unsupported opcodes
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 7) == 0) begin
                do opc = 5'($urandom_range(9, 31));
                while (opc >= 5'd16 && opc <= 5'd19);
            end else begin
                opc = legal_ops[$urandom_range(0, 12)];
            end
            irv = {opc, 27'($urandom)};
            run_instr("random", irv, $urandom_range(0, 3), $urandom_range(0, 2));
        end

        start = 1'b0;
        @(posedge clk); #1;
        check("final_idle", 0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
